// File: rtl/sisc_core.sv
// rtl/sisc_core.sv - multi-cycle SISC core: fetch/decode/exec/mem FSM with register file and status flags
module sisc_core #(
    parameter int DW   = 32,
    parameter int AW   = 16,
    parameter int NREG = 16
) (
    input  logic          clk,
    input  logic          rst_f,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic [AW-1:0] pc,
    output logic [3:0]    stat,
    output logic          halted
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LDX  = 4'h3;
    localparam logic [3:0] OP_STX  = 4'h4;
    localparam logic [3:0] OP_BRA  = 4'h5;
    localparam logic [3:0] OP_BRR  = 4'h6;
    localparam logic [3:0] OP_HLT  = 4'hF;

    logic [2:0]    state;
    logic [31:0]   ir;
    logic [DW-1:0] regs [1:NREG-1];
    logic [DW-1:0] rf [16];

    logic [3:0]  op, mm, rd_i, rs_i, rt_i;
    logic [15:0] imm;

    assign op   = ir[31:28];
    assign mm   = ir[27:24];
    assign rd_i = ir[23:20];
    assign rs_i = ir[19:16];
    assign rt_i = ir[15:12];
    assign imm  = ir[15:0];

    // Full 16-entry read view: R0 and unimplemented indices read as zero.
    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_rf
            if (g == 0 || g >= NREG) begin : g_zero
                assign rf[g] = '0;
            end else begin : g_reg
                assign rf[g] = regs[g];
            end
        end
    endgenerate

    logic [DW-1:0] a, b, d, sext_imm;
    assign a        = rf[rs_i];
    assign b        = rf[rt_i];
    assign d        = rf[rd_i];
    assign sext_imm = DW'($signed(imm));

    logic [DW:0] add_ab, sub_ab, add_ai;
    assign add_ab = {1'b0, a} + {1'b0, b};
    assign sub_ab = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
    assign add_ai = {1'b0, a} + {1'b0, sext_imm};

    function automatic logic [3:0] arith_flags(input logic [DW:0] s, input logic a_msb, input logic b_msb);
        arith_flags = {s[DW], (a_msb == b_msb) && (s[DW-1] != a_msb), s[DW-1], s[DW-1:0] == '0};
    endfunction

    function automatic logic [3:0] logic_flags(input logic c, input logic [DW-1:0] r);
        logic_flags = {c, 1'b0, r[DW-1], r == '0};
    endfunction

    logic [DW-1:0] alu_res;
    logic [3:0]    alu_stat;

    always_comb begin
        alu_res  = a;
        alu_stat = stat;
        case (mm)
            4'h0: begin
                alu_res  = add_ab[DW-1:0];
                alu_stat = arith_flags(add_ab, a[DW-1], b[DW-1]);
            end
            4'h1: begin
                // Subtract as a + ~b + 1 so the carry out means "no borrow".
                alu_res  = sub_ab[DW-1:0];
                alu_stat = arith_flags(sub_ab, a[DW-1], ~b[DW-1]);
            end
            4'h2: begin
                alu_res  = a & b;
                alu_stat = logic_flags(1'b0, a & b);
            end
            4'h3: begin
                alu_res  = a | b;
                alu_stat = logic_flags(1'b0, a | b);
            end
            4'h4: begin
                alu_res  = a ^ b;
                alu_stat = logic_flags(1'b0, a ^ b);
            end
            4'h5: begin
                alu_res  = {a[DW-2:0], 1'b0};
                alu_stat = logic_flags(a[DW-1], {a[DW-2:0], 1'b0});
            end
            4'h6: begin
                alu_res  = {1'b0, a[DW-1:1]};
                alu_stat = logic_flags(a[0], {1'b0, a[DW-1:1]});
            end
            default: ;
        endcase
    end

    logic          br_taken;
    logic [AW-1:0] pc_inc, brr_target;
    assign br_taken   = |(mm & stat);
    assign pc_inc     = pc + AW'(1);
    assign brr_target = pc + imm[AW-1:0];

    logic          wr_en;
    logic [DW-1:0] wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_data = dmem_rdata;
        if (state == S_EXEC && op == OP_ALU) begin
            wr_en   = 1'b1;
            wr_data = alu_res;
        end else if (state == S_EXEC && op == OP_ADDI) begin
            wr_en   = 1'b1;
            wr_data = add_ai[DW-1:0];
        end else if (state == S_MEM && dmem_ack && !dmem_we) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            for (int i = 1; i < NREG; i++) begin
                if (rd_i == 4'(i)) regs[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state      <= S_IDLE;
            pc         <= '0;
            stat       <= '0;
            ir         <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        pc    <= pc_inc;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    state <= S_FETCH;
                    case (op)
                        OP_ALU:  stat <= alu_stat;
                        OP_ADDI: stat <= arith_flags(add_ai, a[DW-1], sext_imm[DW-1]);
                        OP_LDX, OP_STX: begin
                            // Access attributes are registered so they stay put for the whole MEM wait.
                            dmem_we    <= (op == OP_STX);
                            dmem_addr  <= add_ai[AW-1:0];
                            dmem_wdata <= d;
                            state      <= S_MEM;
                        end
                        OP_BRA:  if (br_taken) pc <= imm[AW-1:0];
                        OP_BRR:  if (br_taken) pc <= brr_target;
                        OP_HLT:  state <= S_HALT;
                        default: ;
                    endcase
                end
                S_MEM:    if (dmem_ack) state <= S_FETCH;
                S_HALT:   ;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign dmem_req  = (state == S_MEM);
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_sisc_core.sv
// tb/tb_sisc_core.sv - randomized and directed bench for sisc_core against an ISA-level reference model
module tb_sisc_core;
    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int NREG = 12;

    logic          clk = 1'b0;
    logic          rst_f;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic [AW-1:0] pc;
    logic [3:0]    stat;
    logic          halted;

    always #5 clk = ~clk;

    sisc_core #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk(clk), .rst_f(rst_f),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc(pc), .stat(stat), .halted(halted)
    );

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [31:0] data;
    } mem_op_t;

    logic [31:0] imem_arr [256];
    logic [15:0] fq [$];
    mem_op_t     dq [$];
    logic [31:0] mem_ref [int];
    logic [31:0] mem_dut [int];
    logic [31:0] mr [16];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          waits, cyc, exp_base;
    bit          active = 1'b0;
    bit          spur;
    int          imode, dmode, iw_cnt, iw_tgt, dw_cnt, dw_tgt;
    logic [31:0] last_store;
    logic [15:0] exp_pc;
    logic [3:0]  exp_stat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [15:0] addr);
        return {addr, ~addr} ^ 32'h3C5A_96E1;
    endfunction

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [15:0] imm);
        return {op, mm, rd, rs, imm};
    endfunction

    function automatic logic [31:0] rreg(input logic [3:0] idx);
        return (idx == 0 || int'(idx) >= NREG) ? 32'h0 : mr[idx];
    endfunction

    task automatic wreg(input logic [3:0] idx, input logic [31:0] v);
        if (idx != 0 && int'(idx) < NREG) mr[idx] = v;
    endtask

    function automatic logic [3:0] arith(input bit c, input longint s, input logic [31:0] r);
        return {c, (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000), r[31], r == 32'h0};
    endfunction

    function automatic int pick(input int mode);
        return (mode < 0) ? int'($urandom_range(0, 3)) : mode;
    endfunction

    // ISA interpreter: expected fetch addresses, memory accesses, base cycles, final pc/stat.
    task automatic run_model();
        logic [15:0] mpc, imm, ma;
        logic [3:0]  st, op, mm, rd, rs, rt;
        logic [31:0] ins, a, b, r, sx, v;
        longint      s;
        bit          done;
        for (int i = 0; i < 16; i++) mr[i] = 32'h0;
        mem_ref.delete(); fq.delete(); dq.delete();
        mpc = 16'h0; st = 4'h0; exp_base = 0; done = 1'b0;
        for (int step = 0; step < 500 && !done; step++) begin
            fq.push_back(mpc);
            ins = imem_arr[mpc[7:0]];
            mpc = mpc + 16'h1;
            {op, mm, rd, rs, rt} = ins[31:12];
            imm = ins[15:0];
            a = rreg(rs); b = rreg(rt);
            sx = {{16{imm[15]}}, imm};
            ma = 16'(a + sx);
            exp_base += (op == 4'h3 || op == 4'h4) ? 4 : 3;
            case (op)
                4'h1: begin
                    r = a;
                    case (mm)
                        4'h0: begin r = a + b; s = longint'(signed'(a)) + longint'(signed'(b));
                              st = arith((longint'(a) + longint'(b)) > 64'hFFFF_FFFF, s, r); end
                        4'h1: begin r = a - b; s = longint'(signed'(a)) - longint'(signed'(b));
                              st = arith(a >= b, s, r); end
                        4'h2: begin r = a & b; st = {2'b00, r[31], r == 32'h0}; end
                        4'h3: begin r = a | b; st = {2'b00, r[31], r == 32'h0}; end
                        4'h4: begin r = a ^ b; st = {2'b00, r[31], r == 32'h0}; end
                        4'h5: begin r = a << 1; st = {a[31], 1'b0, r[31], r == 32'h0}; end
                        4'h6: begin r = a >> 1; st = {a[0], 1'b0, r[31], r == 32'h0}; end
                        default: ;
                    endcase
                    wreg(rd, r);
                end
                4'h2: begin
                    r = a + sx; s = longint'(signed'(a)) + longint'(signed'(sx));
                    st = arith((longint'(a) + longint'(sx)) > 64'hFFFF_FFFF, s, r);
                    wreg(rd, r);
                end
                4'h3: begin
                    v = mem_ref.exists(int'(ma)) ? mem_ref[int'(ma)] : init_val(ma);
                    dq.push_back('{1'b0, ma, 32'h0});
                    wreg(rd, v);
                end
                4'h4: begin
                    v = rreg(rd);
                    mem_ref[int'(ma)] = v;
                    dq.push_back('{1'b1, ma, v});
                end
                4'h5: if ((mm & st) != 4'h0) mpc = imm;
                4'h6: if ((mm & st) != 4'h0) mpc = mpc + imm;
                4'hF: done = 1'b1;
                default: ;
            endcase
        end
        exp_pc = mpc;
        exp_stat = st;
    endtask

    // Memory responders with programmable wait states, optional spurious acks while idle.
    initial begin
        imem_ack = 1'b0; imem_rdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!active) begin
                imem_ack = 1'b0; dmem_ack = 1'b0;
                continue;
            end
            if (imem_req) begin
                check("imem_addr", imem_addr, fq.size() != 0 ? 64'(fq[0]) : ~64'h0);
                if (iw_cnt >= iw_tgt) begin
                    imem_ack = 1'b1;
                    imem_rdata = imem_arr[imem_addr[7:0]];
                    if (fq.size() != 0) void'(fq.pop_front());
                    iw_cnt = 0; iw_tgt = pick(imode);
                end else begin
                    imem_ack = 1'b0; iw_cnt++; waits++;
                end
            end else begin
                imem_ack = spur && ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom;
            end
            if (dmem_req) begin
                if (dq.size() == 0) begin
                    check("dmem_unexpected", 64'(dmem_addr), ~64'h0);
                end else begin
                    check("dmem_we", 64'(dmem_we), 64'(dq[0].we));
                    check("dmem_addr", 64'(dmem_addr), 64'(dq[0].addr));
                    if (dq[0].we) check("dmem_wdata", 64'(dmem_wdata), 64'(dq[0].data));
                end
                if (dw_cnt >= dw_tgt) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) begin
                        mem_dut[int'(dmem_addr)] = dmem_wdata;
                        last_store = dmem_wdata;
                    end else begin
                        dmem_rdata = mem_dut.exists(int'(dmem_addr)) ? mem_dut[int'(dmem_addr)] : init_val(dmem_addr);
                    end
                    if (dq.size() != 0) void'(dq.pop_front());
                    dw_cnt = 0; dw_tgt = pick(dmode);
                end else begin
                    dmem_ack = 1'b0; dw_cnt++; waits++;
                end
            end else begin
                dmem_ack = spur && ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    task automatic start_run(input int im, input int dm, input bit sp);
        run_model();
        active = 1'b0;
        @(negedge clk);
        rst_f = 1'b0;
        @(negedge clk);
        check("rst_outs", {imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, pc, stat, halted}, 0);
        mem_dut.delete();
        imode = im; dmode = dm; spur = sp;
        iw_cnt = 0; iw_tgt = pick(im); dw_cnt = 0; dw_tgt = pick(dm);
        waits = 0; last_store = 32'hDEAD_BEEF;
        active = 1'b1;
        @(negedge clk);
        rst_f = 1'b1;
    endtask

    task automatic run_test(input string name, input int im, input int dm, input bit sp);
        start_run(im, dm, sp);
        cyc = 0;
        while (cyc < 3000 && !halted) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_halted"}, 64'(halted), 64'h1);
        check({name, "_cycles"}, 64'(cyc), 64'(1 + exp_base + waits));
        check({name, "_pc"}, 64'(pc), 64'(exp_pc));
        check({name, "_stat"}, 64'(stat), 64'(exp_stat));
        check({name, "_left"}, 64'(fq.size() + dq.size()), 64'h0);
        active = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem_arr[i] = 32'hF000_0000;
    endtask

    task automatic load_t1();
        clear_imem();
        imem_arr[0] = enc(4'h2, 4'h0, 4'd1, 4'd0, 16'd5);
        imem_arr[1] = enc(4'h2, 4'h0, 4'd2, 4'd0, 16'hFFFD);
        imem_arr[2] = enc(4'h1, 4'h0, 4'd3, 4'd1, {4'd2, 12'h0});
        imem_arr[3] = enc(4'h4, 4'h0, 4'd3, 4'd0, 16'h0010);
    endtask

    task automatic gen_random();
        logic [3:0]  op, mm, rd, rs;
        logic [15:0] imm;
        int          r;
        clear_imem();
        for (int p = 0; p < 20; p++) begin
            r = int'($urandom_range(0, 19));
            op = r < 5 ? 4'h1 : r < 9 ? 4'h2 : r < 11 ? 4'h3 : r < 13 ? 4'h4 :
                 r < 15 ? 4'h5 : r < 17 ? 4'h6 : r == 17 ? 4'h0 : 4'($urandom_range(7, 14));
            mm = 4'($urandom); rd = 4'($urandom); rs = 4'($urandom); imm = 16'($urandom);
            if ((op == 4'h3 || op == 4'h4) && $urandom_range(0, 1) == 1) begin
                rs = 4'h0; imm = 16'(16'h40 + $urandom_range(0, 7));
            end
            if (op == 4'h5) imm = 16'($urandom_range(p + 1, 35));
            if (op == 4'h6) imm = 16'($urandom_range(0, 35 - (p + 1)));
            imem_arr[p] = enc(op, mm, rd, rs, imm);
        end
        for (int k = 1; k < 16; k++) imem_arr[19 + k] = enc(4'h4, 4'h0, 4'(k), 4'h0, 16'(16'h100 + k));
        imem_arr[35] = 32'hF000_0000;
    endtask

    initial begin
        rst_f = 1'b0;
        repeat (2) @(negedge clk);

        load_t1();
        run_test("t1", 0, 0, 1'b0);
        check("t1_const_stat", 64'(stat), 64'b1000);
        check("t1_const_r3", 64'(last_store), 64'h2);
        check("t1_const_cycles", 64'(cyc), 64'd17);

        // Halted hold, asynchronous reset during HALT, then first fetch from 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_hold", {halted, imem_req, dmem_req, pc, stat}, {1'b1, 1'b0, 1'b0, 16'h5, 4'b1000});
        end
        #2 rst_f = 1'b0;
        #1 check("halt_rst_outs", {imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, pc, stat, halted}, 0);
        @(negedge clk);
        rst_f = 1'b1;
        #1 check("post_rst_idle", 64'(imem_req), 64'h0);
        @(negedge clk);
        check("post_rst_fetch0", {imem_req, imem_addr}, {1'b1, 16'h0});

        clear_imem();
        imem_arr[0] = enc(4'h2, 4'h0, 4'd1, 4'd0, 16'hFFFF);
        imem_arr[1] = enc(4'h1, 4'h6, 4'd1, 4'd1, 16'h0);
        imem_arr[2] = enc(4'h1, 4'h0, 4'd3, 4'd1, {4'd1, 12'h0});
        imem_arr[3] = enc(4'h4, 4'h0, 4'd3, 4'd0, 16'h0010);
        run_test("t2", -1, -1, 1'b1);
        check("t2_const_stat", 64'(stat), 64'b0110);
        check("t2_const_r3", 64'(last_store), 64'hFFFF_FFFE);

        load_t1();
        run_test("t3", 3, 0, 1'b0);
        check("t3_const_cycles", 64'(cyc), 64'd32);
        check("t3_const_r3", 64'(last_store), 64'h2);

        clear_imem();
        imem_arr[0] = enc(4'h2, 4'h0, 4'd1, 4'd0, 16'h0055);
        imem_arr[1] = enc(4'h4, 4'h0, 4'd1, 4'd0, 16'h0010);
        imem_arr[2] = enc(4'h3, 4'h0, 4'd4, 4'd0, 16'h0010);
        imem_arr[3] = enc(4'h4, 4'h0, 4'd4, 4'd0, 16'h0020);
        run_test("t4", 0, 2, 1'b0);
        check("t4_const_cycles", 64'(cyc), 64'd25);
        check("t4_const_r4", 64'(last_store), 64'h55);
        check("t4_const_stat", 64'(stat), 64'h0);

        // Reset while a load waits in MEM: access aborted, architectural state cleared.
        start_run(0, 6, 1'b0);
        for (int i = 0; i < 100 && !(dmem_req && !dmem_we); i++) @(negedge clk);
        check("abort_in_mem", {dmem_req, dmem_we}, 2'b10);
        #2 rst_f = 1'b0;
        #1 check("abort_state", {pc, stat, dmem_req, imem_req, halted}, 0);
        active = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;

        clear_imem();
        imem_arr[0] = enc(4'h2, 4'h0, 4'd2, 4'd0, 16'h0001);
        imem_arr[1] = enc(4'h2, 4'h0, 4'd2, 4'd2, 16'hFFFF);
        imem_arr[2] = enc(4'h6, 4'h1, 4'd0, 4'd0, 16'hFFFE);
        imem_arr[3] = enc(4'h4, 4'h0, 4'd2, 4'd0, 16'h0010);
        run_test("t5", -1, -1, 1'b1);
        check("t5_const_pc", 64'(pc), 64'h5);
        check("t5_const_stat", 64'(stat), 64'b0010);
        check("t5_const_cycles", 64'(cyc), 64'(23 + waits));

        for (int t = 0; t < 10; t++) begin
            gen_random();
            run_test($sformatf("rnd%0d", t), -1, -1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
